// File: rtl/conv_job_sequencer_pkg.sv
// rtl/conv_job_sequencer_pkg.sv - FSM state encoding and output-geometry helpers shared by the sequencer files
package conv_job_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_SEND = 3'd3,
    ST_ERR  = 3'd4
  } seq_state_e;

  // Output map edge for one spatial dimension of the convolution.
  function automatic int conv_out_dim(input int n, input int k, input int pad, input int stride);
    return (n - k + 2 * pad) / stride + 1;
  endfunction

  function automatic int conv_n_out(input int col, input int row, input int k, input int pad,
                                    input int stride, input int depth);
    return depth * conv_out_dim(col, k, pad, stride) * conv_out_dim(row, k, pad, stride);
  endfunction

  // Counter width for an index that must reach n-1; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_out_serializer.sv
// rtl/conv_out_serializer.sv - holds the captured result vector and presents it one word per handshake
module conv_out_serializer
  import conv_job_sequencer_pkg::*;
#(
  parameter int out_width = 8,
  parameter int n_out     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [n_out*out_width-1:0]   y,
  input  logic                         ready,
  output logic [out_width-1:0]         out_data,
  output logic                         out_last,
  output logic                         empty
);

  localparam int idx_w = idx_bits(n_out);

  logic [out_width-1:0] ybuf_q [n_out];
  logic [out_width-1:0] ybuf_d [n_out];
  logic [idx_w-1:0]     idx_q, idx_d;
  logic                 full_q, full_d;
  logic [out_width-1:0] data_q, data_d;
  logic                 at_last;

  assign at_last  = full_q && (idx_q == idx_w'(n_out - 1));
  assign out_data = data_q;
  assign out_last = at_last;
  assign empty    = !full_q;

  // out_data is registered, so the next word is fetched on the same edge as the handshake.
  always_comb begin
    ybuf_d = ybuf_q;
    idx_d  = idx_q;
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      for (int i = 0; i < n_out; i++) begin
        ybuf_d[i] = y[i*out_width +: out_width];
      end
      idx_d  = '0;
      full_d = 1'b1;
      data_d = y[out_width-1:0];
    end else if (ready && full_q) begin
      if (at_last) begin
        idx_d  = '0;
        full_d = 1'b0;
      end else begin
        idx_d  = idx_q + idx_w'(1);
        data_d = ybuf_q[idx_q + idx_w'(1)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < n_out; i++) begin
        ybuf_q[i] <= '0;
      end
      idx_q  <= '0;
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      ybuf_q <= ybuf_d;
      idx_q  <= idx_d;
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/conv_job_sequencer.sv
// rtl/conv_job_sequencer.sv - job controller: latches operands, clears and runs the conv datapath under a timeout, streams the result
module conv_job_sequencer
  import conv_job_sequencer_pkg::*;
#(
  parameter int width     = 8,
  parameter int out_width = 8,
  parameter int col       = 3,
  parameter int row       = 3,
  parameter int channel   = 3,
  parameter int depth     = 2,
  parameter int k_size    = 2,
  parameter int stride    = 1,
  parameter int pad_size  = 1,
  parameter int timeout   = 64,
  localparam int n_out    = conv_n_out(col, row, k_size, pad_size, stride, depth),
  localparam int a_w      = col * row * channel * width,
  localparam int b_w      = depth * k_size * k_size * channel * width,
  localparam int c_w      = depth * out_width,
  localparam int kmap_w   = width * channel,
  localparam int y_w      = n_out * out_width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [a_w-1:0]       in_a,
  input  logic [b_w-1:0]       in_b,
  input  logic [c_w-1:0]       in_c,
  input  logic [kmap_w-1:0]    in_kmap,
  output logic                 conv_rst,
  output logic                 conv_en,
  output logic [a_w-1:0]       conv_a,
  output logic [b_w-1:0]       conv_b,
  output logic [c_w-1:0]       conv_c,
  output logic [kmap_w-1:0]    conv_kmap,
  input  logic [y_w-1:0]       conv_y,
  input  logic                 conv_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [out_width-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int tmr_w = $clog2(timeout);

  seq_state_e          state_q, state_d;
  logic [tmr_w-1:0]    tmr_q, tmr_d;
  logic [a_w-1:0]      a_q, a_d;
  logic [b_w-1:0]      b_q, b_d;
  logic [c_w-1:0]      c_q, c_d;
  logic [kmap_w-1:0]   kmap_q, kmap_d;
  logic                conv_rst_q, conv_rst_d;
  logic                conv_en_q, conv_en_d;
  logic                err_q, err_d;

  logic                ser_load;
  logic                ser_ready;
  logic                ser_last;
  logic                ser_empty;
  logic [out_width-1:0] ser_data;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    kmap_d   = kmap_q;
    ser_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          kmap_d  = in_kmap;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        tmr_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // done is checked first so a result arriving on the final allowed cycle is still kept
        if (conv_done) begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end else if (tmr_q == tmr_w'(timeout - 1)) begin
          state_d = ST_ERR;
        end else begin
          tmr_d = tmr_q + tmr_w'(1);
        end
      end
      ST_SEND: begin
        if (out_ready && ser_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (err_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    conv_rst_d = (state_d == ST_IDLE) || (state_d == ST_CLR) || (state_d == ST_ERR);
    conv_en_d  = (state_d == ST_RUN);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      kmap_q     <= '0;
      conv_rst_q <= 1'b1;
      conv_en_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      kmap_q     <= kmap_d;
      conv_rst_q <= conv_rst_d;
      conv_en_q  <= conv_en_d;
      err_q      <= err_d;
    end
  end

  assign ser_ready = out_ready && (state_q == ST_SEND);

  conv_out_serializer #(
    .out_width (out_width),
    .n_out     (n_out)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .y        (conv_y),
    .ready    (ser_ready),
    .out_data (ser_data),
    .out_last (ser_last),
    .empty    (ser_empty)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_SEND) && !ser_empty;
  assign out_last  = out_valid && ser_last;
  assign out_data  = ser_data;
  assign conv_rst  = conv_rst_q;
  assign conv_en   = conv_en_q;
  assign conv_a    = a_q;
  assign conv_b    = b_q;
  assign conv_c    = c_q;
  assign conv_kmap = kmap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb/tb_conv_job_sequencer.sv - randomized self-checking bench with a behavioural datapath stub
module tb_conv_job_sequencer;

  localparam int WIDTH = 8, OUT_W = 8, COL = 3, ROW = 3, CH = 3, DEPTH = 2;
  localparam int KS = 2, STRIDE = 1, PAD = 1, TIMEOUT = 64;
  localparam int COL_SIZE = (COL - KS + 2 * PAD) / STRIDE + 1;
  localparam int ROW_SIZE = (ROW - KS + 2 * PAD) / STRIDE + 1;
  localparam int N_OUT = DEPTH * COL_SIZE * ROW_SIZE;
  localparam int A_W = COL * ROW * CH * WIDTH;
  localparam int B_W = DEPTH * KS * KS * CH * WIDTH;
  localparam int C_W = DEPTH * OUT_W;
  localparam int K_W = WIDTH * CH;
  localparam int Y_W = N_OUT * OUT_W;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [A_W-1:0] in_a, conv_a;
  logic [B_W-1:0] in_b, conv_b;
  logic [C_W-1:0] in_c, conv_c;
  logic [K_W-1:0] in_kmap, conv_kmap;
  logic conv_rst, conv_en, conv_done;
  logic [Y_W-1:0] conv_y;
  logic out_valid, out_ready, out_last, busy, err, err_clr;
  logic [OUT_W-1:0] out_data;

  always #5 clk = ~clk;

  conv_job_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_kmap(in_kmap),
    .conv_rst(conv_rst), .conv_en(conv_en), .conv_a(conv_a), .conv_b(conv_b),
    .conv_c(conv_c), .conv_kmap(conv_kmap), .conv_y(conv_y), .conv_done(conv_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  // Datapath stub: done during the K-th enabled cycle, result word i = i+1.
  int k_cycles = 1;
  bit stub_hang = 1'b0;
  int en_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) en_cnt <= 0;
    else     en_cnt <= conv_en ? en_cnt + 1 : 0;
  end
  assign conv_done = conv_en && !stub_hang && (en_cnt == k_cycles - 1);
  for (genvar g = 0; g < N_OUT; g++) begin : g_y
    assign conv_y[g*OUT_W +: OUT_W] = OUT_W'(g + 1);
  end

  int checks, errors;
  logic [A_W-1:0] exp_a;
  logic [B_W-1:0] exp_b;
  logic [C_W-1:0] exp_c;
  logic [K_W-1:0] exp_kmap;
  int got_q[$];
  int en_cycles, last_cnt, last_pos, stall_bad, opnd_bad;
  int first_valid_cyc, last_en_cyc, first_word_cyc, last_word_cyc;
  bit clr_ok, finished, err_seen, ready_at_start, post_ready;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic new_operands();
    logic [255:0] r;
    r = rnd256(); in_a = r[A_W-1:0];
    r = rnd256(); in_b = r[B_W-1:0];
    r = rnd256(); in_c = r[C_W-1:0]; in_kmap = r[C_W+K_W-1:C_W];
  endtask

  // Reference: the stream must be exactly (i+1) mod 2^OUT_W for i = 0..N_OUT-1.
  function automatic int seq_errs();
    int n = 0;
    if (got_q.size() != N_OUT) n++;
    for (int i = 0; i < got_q.size() && i < N_OUT; i++)
      if (got_q[i] != ((i + 1) % (1 << OUT_W))) n++;
    return n;
  endfunction

  // Runs one job from a negedge and records what it observes; the calling test does the checking.
  task automatic do_job(input int k, input int mode, input bit hold, input int abort_en, input int abort_words);
    bit prev_stall;
    logic [OUT_W-1:0] prev_data;
    logic prev_last;
    k_cycles = k;
    got_q.delete();
    en_cycles = 0; last_cnt = 0; last_pos = -1; stall_bad = 0; opnd_bad = 0;
    first_valid_cyc = -1; last_en_cyc = -1; first_word_cyc = -1; last_word_cyc = -1;
    clr_ok = 0; finished = 0; err_seen = 0; post_ready = 0; prev_stall = 0;
    prev_data = '0; prev_last = 1'b0;
    ready_at_start = in_ready;
    new_operands();
    in_valid = 1'b1;
    exp_a = in_a; exp_b = in_b; exp_c = in_c; exp_kmap = in_kmap;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 0) clr_ok = (conv_rst === 1'b1) && (conv_en === 1'b0) && (busy === 1'b1) && (in_ready === 1'b0);
      if (conv_en === 1'b1) begin en_cycles++; last_en_cyc = cyc; end
      if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (conv_a !== exp_a || conv_b !== exp_b || conv_c !== exp_c || conv_kmap !== exp_kmap) opnd_bad++;
      if (prev_stall && (out_data !== prev_data || out_last !== prev_last)) stall_bad++;
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data = out_data; prev_last = out_last;
      if (err === 1'b1) begin err_seen = 1; return; end
      if (out_valid === 1'b1 && out_ready) begin
        got_q.push_back(int'(out_data));
        if (first_word_cyc < 0) first_word_cyc = cyc;
        last_word_cyc = cyc;
        if (out_last === 1'b1) begin last_cnt++; last_pos = got_q.size(); end
      end
      if (abort_en >= 0 && en_cycles == abort_en) return;
      if (abort_words >= 0 && got_q.size() == abort_words) return;
      if (out_valid === 1'b1 && out_ready && out_last === 1'b1) begin
        finished = 1;
        @(negedge clk);
        post_ready = (in_ready === 1'b1) && (busy === 1'b0);
        return;
      end
      @(negedge clk);
      if (hold) new_operands();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, conv_rst, conv_en, out_valid, out_last, busy, err} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1100000", {in_ready, conv_rst, conv_en, out_valid, out_last, busy, err});
    end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++;
    if ((|conv_a) || (|conv_b) || (|conv_c) || (|conv_kmap)) begin
      errors++; $display("FAIL reset_operands: got nonzero expected 0");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    do_job(5, 0, 0, -1, -1);
    checks++; if (!ready_at_start) begin errors++; $display("FAIL basic_ready: got 0 expected 1"); end
    checks++; if (!clr_ok) begin errors++; $display("FAIL basic_clr: got 0 expected 1"); end
    checks++; if (en_cycles != 5) begin errors++; $display("FAIL basic_en_cycles: got %0d expected 5", en_cycles); end
    checks++; if (seq_errs() != 0) begin errors++; $display("FAIL basic_words: got %0d words %0d bad expected %0d 0", got_q.size(), seq_errs(), N_OUT); end
    checks++; if (last_cnt != 1 || last_pos != N_OUT) begin errors++; $display("FAIL basic_last: got count %0d pos %0d expected 1 %0d", last_cnt, last_pos, N_OUT); end
    checks++; if (first_valid_cyc != last_en_cyc + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", first_valid_cyc, last_en_cyc + 1); end
    checks++; if (last_word_cyc - first_word_cyc != N_OUT - 1) begin errors++; $display("FAIL basic_throughput: got %0d expected %0d", last_word_cyc - first_word_cyc, N_OUT - 1); end
    checks++; if (!post_ready) begin errors++; $display("FAIL basic_return_idle: got 0 expected 1"); end
    checks++; if (opnd_bad != 0) begin errors++; $display("FAIL basic_operands: got %0d bad expected 0", opnd_bad); end
  endtask

  task automatic test_backpressure();
    do_job(5, 1, 0, -1, -1);
    checks++; if (!finished) begin errors++; $display("FAIL bp_finished: got 0 expected 1"); end
    checks++; if (seq_errs() != 0) begin errors++; $display("FAIL bp_words: got %0d words %0d bad expected %0d 0", got_q.size(), seq_errs(), N_OUT); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d expected 0", stall_bad); end
    checks++; if (last_cnt != 1) begin errors++; $display("FAIL bp_last: got %0d expected 1", last_cnt); end
  endtask

  task automatic test_timeout();
    stub_hang = 1'b1;
    do_job(1, 0, 0, -1, -1);
    checks++; if (!err_seen) begin errors++; $display("FAIL to_err: got 0 expected 1"); end
    checks++; if (en_cycles != TIMEOUT) begin errors++; $display("FAIL to_en_cycles: got %0d expected %0d", en_cycles, TIMEOUT); end
    checks++;
    if (conv_en !== 1'b0 || in_ready !== 1'b0 || conv_rst !== 1'b1) begin
      errors++; $display("FAIL to_state: got en=%b ready=%b rst=%b expected 0 0 1", conv_en, in_ready, conv_rst);
    end
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL to_sticky: got err=%b busy=%b expected 1 1", err, busy); end
    in_valid = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL to_clear: got err=%b ready=%b expected 0 1", err, in_ready); end
    stub_hang = 1'b0;
  endtask

  task automatic test_timeout_race();
    do_job(TIMEOUT, 0, 0, -1, -1);
    checks++; if (err_seen || !finished) begin errors++; $display("FAIL race_done_wins: got err=%0d finished=%0d expected 0 1", err_seen, finished); end
    checks++; if (en_cycles != TIMEOUT) begin errors++; $display("FAIL race_en_cycles: got %0d expected %0d", en_cycles, TIMEOUT); end
    checks++; if (seq_errs() != 0) begin errors++; $display("FAIL race_words: got %0d bad expected 0", seq_errs()); end
  endtask

  task automatic test_rst_mid_job();
    do_job(20, 0, 0, 3, -1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, conv_rst, conv_en, out_valid, out_last, busy, err} !== 7'b1100000 || (|conv_a)) begin
      errors++; $display("FAIL rst_in_run: got %b expected 1100000", {in_ready, conv_rst, conv_en, out_valid, out_last, busy, err});
    end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    do_job(4, 2, 0, -1, 10);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_in_send: got valid=%b last=%b data=%0d busy=%b expected 0 0 0 0", out_valid, out_last, out_data, busy);
    end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    do_job(5, 0, 0, -1, -1);
    checks++; if (seq_errs() != 0 || !finished) begin errors++; $display("FAIL rst_recover_words: got %0d words %0d bad expected %0d 0", got_q.size(), seq_errs(), N_OUT); end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) begin
      do_job(int'($urandom_range(1, 12)), 0, 1, -1, -1);
      checks++; if (!ready_at_start) begin errors++; $display("FAIL b2b_accept_%0d: got 0 expected 1", j); end
      checks++; if (!clr_ok) begin errors++; $display("FAIL b2b_clr_%0d: got 0 expected 1", j); end
      checks++; if (opnd_bad != 0) begin errors++; $display("FAIL b2b_operands_%0d: got %0d bad expected 0", j, opnd_bad); end
      checks++; if (seq_errs() != 0 || !finished) begin errors++; $display("FAIL b2b_words_%0d: got %0d bad expected 0", j, seq_errs()); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      int k;
      k = int'($urandom_range(1, 40));
      do_job(k, 2, 0, -1, -1);
      checks++; if (en_cycles != k) begin errors++; $display("FAIL rnd_en_%0d: got %0d expected %0d", j, en_cycles, k); end
      checks++; if (seq_errs() != 0 || !finished) begin errors++; $display("FAIL rnd_words_%0d: got %0d bad expected 0", j, seq_errs()); end
      checks++; if (stall_bad != 0 || opnd_bad != 0) begin errors++; $display("FAIL rnd_stable_%0d: got %0d/%0d expected 0/0", j, stall_bad, opnd_bad); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_kmap = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_timeout_race();
    test_rst_mid_job();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
